// File: rtl/axis_seq_checker.sv
// AXI4-Stream sink that checks an incrementing test pattern burst.
// It reports beat, mismatch and tlast-position results and can apply periodic back-pressure.
module axis_seq_checker #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_WORDS    = 16,
  parameter logic [DATA_WIDTH-1:0] START_VALUE  = '0,
  parameter int                    STALL_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_axi_txn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [15:0]           rx_count,
  output logic [15:0]           err_count,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  len_err,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [16:0] LAST_BEAT = 17'(NUM_WORDS);
  localparam logic [15:0] STALL_P   = 16'(STALL_PERIOD);

  state_t                state, state_nxt;
  logic                  init_q, start, accept, last_beat, mismatch, stall_hit;
  logic                  tready_nxt, len_nxt;
  logic [16:0]           rx_inc;
  logic [15:0]           rx_nxt, err_nxt, stall_cnt, stall_nxt;
  logic [DATA_WIDTH-1:0] expected, exp_nxt, ferr_nxt;

  assign start     = init_axi_txn & ~init_q;
  assign accept    = (state == RECV) & s_axis_tvalid & s_axis_tready;
  assign rx_inc    = {1'b0, rx_count} + 17'd1;
  assign last_beat = (rx_inc == LAST_BEAT);
  assign mismatch  = (s_axis_tdata != expected);
  assign stall_hit = (STALL_PERIOD > 0) && ((stall_cnt + 16'd1) == STALL_P);

  always_comb begin
    state_nxt  = state;
    tready_nxt = 1'b0;
    rx_nxt     = rx_count;
    err_nxt    = err_count;
    ferr_nxt   = first_err_data;
    len_nxt    = len_err;
    exp_nxt    = expected;
    stall_nxt  = stall_cnt;
    if (start) begin
      // start from any state, including mid-burst, restarts a clean capture
      state_nxt  = RECV;
      tready_nxt = 1'b1;
      rx_nxt     = '0;
      err_nxt    = '0;
      ferr_nxt   = '0;
      len_nxt    = 1'b0;
      exp_nxt    = START_VALUE;
      stall_nxt  = '0;
    end else begin
      case (state)
        RECV: begin
          tready_nxt = 1'b1;
          if (accept) begin
            rx_nxt = rx_inc[15:0];
            if (mismatch) begin
              if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
              if (err_count == 16'd0)    ferr_nxt = s_axis_tdata;
            end
            // resync on received data so a single bad word costs one extra error
            exp_nxt = s_axis_tdata + DATA_WIDTH'(1);
            if (s_axis_tlast != last_beat) len_nxt = 1'b1;
            if (stall_hit) begin
              stall_nxt  = '0;
              tready_nxt = 1'b0;
            end else begin
              stall_nxt = stall_cnt + 16'd1;
            end
            if (last_beat) begin
              state_nxt  = DONE;
              tready_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      init_q         <= 1'b0;
      s_axis_tready  <= 1'b0;
      rx_count       <= '0;
      err_count      <= '0;
      first_err_data <= '0;
      len_err        <= 1'b0;
      expected       <= START_VALUE;
      stall_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      init_q         <= init_axi_txn;
      s_axis_tready  <= tready_nxt;
      rx_count       <= rx_nxt;
      err_count      <= err_nxt;
      first_err_data <= ferr_nxt;
      len_err        <= len_nxt;
      expected       <= exp_nxt;
      stall_cnt      <= stall_nxt;
    end
  end

  assign busy = (state == RECV);
  assign done = (state == DONE);
  assign pass = done & (err_count == 16'd0) & ~len_err;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed plus randomized bench for axis_seq_checker using three configurations:
// defaults, STALL_PERIOD=4, and a wrapping START_VALUE with NUM_WORDS=4.
module tb_axis_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init [3];
  logic [31:0] tdata [3];
  logic        tvalid [3];
  logic        tlast [3];
  logic        tready [3];
  logic [15:0] rxc [3];
  logic [15:0] errc [3];
  logic [31:0] ferr [3];
  logic        lenerr [3];
  logic        busy [3];
  logic        done [3];
  logic        pass [3];

  int          checks = 0;
  int          errors = 0;
  int          nw [3] = '{16, 16, 4};
  logic [31:0] sv [3] = '{32'h0, 32'h0, 32'hFFFFFFFE};
  int          stall_p [3] = '{0, 4, 0};

  logic [31:0] bd [$];
  bit          bl [$];
  int          stall_log [$];
  int          m_rx, m_err;
  logic [31:0] m_ferr;
  bit          m_len, m_pass;

  always #5 clk = ~clk;

  axis_seq_checker u_def (
    .clk(clk), .rst_n(rst_n), .init_axi_txn(init[0]),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tlast(tlast[0]),
    .s_axis_tready(tready[0]), .rx_count(rxc[0]), .err_count(errc[0]),
    .first_err_data(ferr[0]), .len_err(lenerr[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]));

  axis_seq_checker #(.STALL_PERIOD(4)) u_stall (
    .clk(clk), .rst_n(rst_n), .init_axi_txn(init[1]),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tlast(tlast[1]),
    .s_axis_tready(tready[1]), .rx_count(rxc[1]), .err_count(errc[1]),
    .first_err_data(ferr[1]), .len_err(lenerr[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]));

  axis_seq_checker #(.NUM_WORDS(4), .START_VALUE(32'hFFFFFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .init_axi_txn(init[2]),
    .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]), .s_axis_tlast(tlast[2]),
    .s_axis_tready(tready[2]), .rx_count(rxc[2]), .err_count(errc[2]),
    .first_err_data(ferr[2]), .len_err(lenerr[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: results follow from the list of beats the checker accepted.
  task automatic model(input int words, input logic [31:0] first);
    logic [31:0] e = first;
    m_err = 0; m_ferr = '0; m_len = 0;
    m_rx = (bd.size() < words) ? bd.size() : words;
    for (int i = 0; i < m_rx; i++) begin
      if (bd[i] !== e) begin
        if (m_err == 0) m_ferr = bd[i];
        if (m_err < 65535) m_err++;
      end
      e = bd[i] + 32'd1;
      if (bl[i] != (i + 1 == words)) m_len = 1;
    end
    m_pass = (m_rx == words) && (m_err == 0) && !m_len;
  endtask

  task automatic load_seq(input logic [31:0] first, input int n, input int words);
    bd.delete(); bl.delete();
    for (int i = 0; i < n; i++) begin
      bd.push_back(first + 32'(i));
      bl.push_back(i + 1 == words);
    end
  endtask

  task automatic pulse_init(input int idx);
    init[idx] = 1'b1;
    @(posedge clk); #1;
    init[idx] = 1'b0;
  endtask

  // AXI master: holds each beat until the handshake; mode 0 always valid, 1 toggling, 2 random.
  task automatic drive(input int idx, input int nb, input int mode, output int cyc);
    int  i = 0;
    bit  v, hs;
    cyc = 0;
    stall_log.delete();
    while (i < nb && cyc < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      tvalid[idx] = v;
      tdata[idx]  = bd[i];
      tlast[idx]  = bl[i];
      @(negedge clk);
      if (!tready[idx]) stall_log.push_back(cyc + 1);
      hs = v && tready[idx];
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    tvalid[idx] = 1'b0;
    tlast[idx]  = 1'b0;
    chk("beats_taken", 32'(i), 32'(nb));
  endtask

  task automatic check_res(input int idx, input string tag);
    model(nw[idx], sv[idx]);
    chk({tag, ".rx_count"}, 32'(rxc[idx]), 32'(m_rx));
    chk({tag, ".err_count"}, 32'(errc[idx]), 32'(m_err));
    chk({tag, ".first_err"}, ferr[idx], m_ferr);
    chk({tag, ".len_err"}, 32'(lenerr[idx]), 32'(m_len));
    chk({tag, ".done"}, 32'(done[idx]), 32'(m_rx == nw[idx]));
    chk({tag, ".pass"}, 32'(pass[idx]), 32'(m_pass));
  endtask

  initial begin
    int cyc;
    int exp_stalls [$];
    for (int k = 0; k < 3; k++) begin
      init[k] = 0; tdata[k] = '0; tvalid[k] = 0; tlast[k] = 0;
    end
    #22;
    for (int k = 0; k < 3; k++) begin
      chk("rst.tready", 32'(tready[k]), 0);
      chk("rst.busy", 32'(busy[k]), 0);
      chk("rst.done", 32'(done[k]), 0);
      chk("rst.pass", 32'(pass[k]), 0);
      chk("rst.rx_count", 32'(rxc[k]), 0);
      chk("rst.err_count", 32'(errc[k]), 0);
      chk("rst.first_err", ferr[k], 0);
      chk("rst.len_err", 32'(lenerr[k]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // clean burst, init held high throughout: exactly one burst
    load_seq(0, 16, 16);
    init[0] = 1'b1;
    @(posedge clk); #1;
    chk("clean.tready_after_start", 32'(tready[0]), 1);
    chk("clean.busy_after_start", 32'(busy[0]), 1);
    drive(0, 16, 0, cyc);
    chk("clean.cycles", 32'(cyc), 16);
    chk("clean.no_stalls", 32'(stall_log.size()), 0);
    chk("clean.tready_at_done", 32'(tready[0]), 0);
    check_res(0, "clean");
    repeat (3) @(posedge clk);
    #1;
    chk("held_init.done", 32'(done[0]), 1);
    chk("held_init.busy", 32'(busy[0]), 0);
    init[0] = 1'b0;
    @(posedge clk); #1;

    // single corrupted word plus resync
    load_seq(0, 16, 16);
    bd[5] = 32'hDEADBEEF;
    pulse_init(0);
    drive(0, 16, 0, cyc);
    check_res(0, "corrupt");
    chk("corrupt.err2", 32'(errc[0]), 2);
    chk("corrupt.first", ferr[0], 32'hDEADBEEF);

    // back-pressure every 4 beats
    load_seq(0, 16, 16);
    pulse_init(1);
    drive(1, 16, 0, cyc);
    chk("stall.cycles", 32'(cyc), 32'(16 + (16 - 1) / stall_p[1]));
    exp_stalls.delete();
    for (int j = 1; j * stall_p[1] < 16; j++) exp_stalls.push_back(j * (stall_p[1] + 1));
    chk("stall.count", 32'(stall_log.size()), 32'(exp_stalls.size()));
    for (int j = 0; j < exp_stalls.size() && j < stall_log.size(); j++)
      chk("stall.cycle", 32'(stall_log[j]), 32'(exp_stalls[j]));
    check_res(1, "stall");

    // master toggles tvalid
    load_seq(0, 16, 16);
    pulse_init(0);
    drive(0, 16, 1, cyc);
    chk("toggle.cycles", 32'(cyc), 31);
    check_res(0, "toggle");

    // wrap of expected value with misplaced tlast
    load_seq(32'hFFFFFFFE, 4, 4);
    bl[1] = 1; bl[3] = 0;
    pulse_init(2);
    drive(2, 4, 0, cyc);
    check_res(2, "wrap");
    chk("wrap.len_err", 32'(lenerr[2]), 1);

    // restart mid-burst after 7 beats
    load_seq(0, 16, 16);
    pulse_init(0);
    drive(0, 7, 0, cyc);
    chk("restart.rx7", 32'(rxc[0]), 7);
    pulse_init(0);
    chk("restart.cleared", 32'(rxc[0]), 0);
    chk("restart.busy", 32'(busy[0]), 1);
    drive(0, 16, 0, cyc);
    check_res(0, "restart");

    // randomized bursts with random tvalid, corruption and tlast errors
    for (int r = 0; r < 8; r++) begin
      load_seq(0, 16, 16);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 5) == 0) bd[i] = $urandom;
        if ($urandom_range(0, 15) == 0) bl[i] = !bl[i];
      end
      pulse_init(0);
      drive(0, 16, 2, cyc);
      check_res(0, "rand");
    end

    // asynchronous reset mid-burst
    load_seq(0, 16, 16);
    pulse_init(0);
    drive(0, 5, 0, cyc);
    tvalid[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.tready", 32'(tready[0]), 0);
    chk("arst.busy", 32'(busy[0]), 0);
    chk("arst.rx_count", 32'(rxc[0]), 0);
    chk("arst.err_count", 32'(errc[0]), 0);
    chk("arst.done", 32'(done[0]), 0);
    tvalid[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst.idle_after", 32'(busy[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
